// File: rtl/imm12_encoder_pkg.sv
// Shared definitions for the ARM operand-2 immediate encoder and its decode counterpart.
// Holds the ISA-fixed sizes, the search FSM state type and the rotate helper.
// Ports: none (package).
package imm12_encoder_pkg;

    localparam int ROT_STEPS = 16;
    localparam int IMM8_W    = 8;
    localparam int OPERAND_W = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Rotate left modulo 32. A doubled copy keeps the expression free of
    // variable right-shift widths that differ between tools.
    function automatic logic [31:0] rol32(input logic [31:0] value, input logic [4:0] amt);
        logic [63:0] tmp;
        tmp = {value, value} << amt;
        return tmp[63:32];
    endfunction

endpackage

// File: rtl/imm12_encoder_if.sv
// Request/result bus of the immediate encoder, valid/ready on both sides.
// master = requester/consumer (drives requests and out_ready), slave = encoder.
// Signals: in_valid/in_ready/in_value/in_allow_inv, out_valid/out_ready/out_found/out_inv/out_operand.
interface imm12_encoder_if;
    import imm12_encoder_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_value;
    logic                 in_allow_inv;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_found;
    logic                 out_inv;
    logic [OPERAND_W-1:0] out_operand;

    modport master (
        output in_valid, in_value, in_allow_inv, out_ready,
        input  in_ready, out_valid, out_found, out_inv, out_operand
    );

    modport slave (
        input  in_valid, in_value, in_allow_inv, out_ready,
        output in_ready, out_valid, out_found, out_inv, out_operand
    );

endinterface

// File: rtl/imm12_encoder_rot_check.sv
// Tests one rotate_imm value: does value (or ~value) fit in imm8 after undoing the rotation.
// Latency: purely combinational. Backpressure: none.
// Ports: value_i, rot_i, allow_inv_i -> hit_dir_o, hit_inv_o, imm8_o (direct byte if hit_dir_o).
module imm12_encoder_rot_check
    import imm12_encoder_pkg::*;
(
    input  logic [31:0]       value_i,
    input  logic [3:0]        rot_i,
    input  logic              allow_inv_i,
    output logic              hit_dir_o,
    output logic              hit_inv_o,
    output logic [IMM8_W-1:0] imm8_o
);

    logic [31:0] cand_dir;
    logic [31:0] cand_inv;

    // Decode rotates imm8 right by 2*rot, so the encoder rotates left by the same amount.
    assign cand_dir  = rol32(value_i,  {rot_i, 1'b0});
    assign cand_inv  = rol32(~value_i, {rot_i, 1'b0});

    assign hit_dir_o = (cand_dir[31:IMM8_W] == '0);
    assign hit_inv_o = allow_inv_i && (cand_inv[31:IMM8_W] == '0);
    assign imm8_o    = hit_dir_o ? cand_dir[IMM8_W-1:0] : cand_inv[IMM8_W-1:0];

endmodule

// File: rtl/imm12_encoder.sv
// Searches rotate_imm 0..15 for an ARM imm12 encoding of a constant (optionally of its inverse).
// Latency: ceil((k+1)/ROT_PER_CYCLE)+1 edges from accept to out_valid (k = hit rotation, 15 on miss).
// Backpressure: one request in flight; result held stable in DONE until out_ready, in_ready only in IDLE.
// Ports: clk, rst_n (async active-low), bus (slave side of imm12_encoder_if).
module imm12_encoder
    import imm12_encoder_pkg::*;
#(
    parameter int ROT_PER_CYCLE = 1,
    parameter int ROT_STEPS     = imm12_encoder_pkg::ROT_STEPS
) (
    input  logic           clk,
    input  logic           rst_n,
    imm12_encoder_if.slave bus
);

    state_t               state_q, state_d;
    logic [31:0]          value_q;
    logic                 allow_inv_q;
    logic [3:0]           rot_cnt_q;
    logic                 found_q;
    logic                 inv_q;
    logic [OPERAND_W-1:0] operand_q;
    logic                 out_valid_q;

    // Per-lane rotation check results.
    logic                 hit_dir [ROT_PER_CYCLE];
    logic                 hit_inv [ROT_PER_CYCLE];
    logic [IMM8_W-1:0]    imm8    [ROT_PER_CYCLE];

    logic                 sel_hit;
    logic                 sel_inv;
    logic [3:0]           sel_rot;
    logic [IMM8_W-1:0]    sel_imm;
    logic                 last_step;

    for (genvar g = 0; g < ROT_PER_CYCLE; g++) begin : g_lane
        imm12_encoder_rot_check u_rot_check (
            .value_i     (value_q),
            .rot_i       (rot_cnt_q + 4'(g)),
            .allow_inv_i (allow_inv_q),
            .hit_dir_o   (hit_dir[g]),
            .hit_inv_o   (hit_inv[g]),
            .imm8_o      (imm8[g])
        );
    end

    // Walk lanes from highest to lowest so the lowest rotation overrides.
    // Within a lane, a direct hit beats an inverted one.
    always_comb begin
        sel_hit = 1'b0;
        sel_inv = 1'b0;
        sel_rot = '0;
        sel_imm = '0;
        for (int g = ROT_PER_CYCLE - 1; g >= 0; g--) begin
            if (hit_dir[g] || hit_inv[g]) begin
                sel_hit = 1'b1;
                sel_inv = !hit_dir[g];
                sel_rot = rot_cnt_q + 4'(g);
                sel_imm = imm8[g];
            end
        end
    end

    assign last_step = (({1'b0, rot_cnt_q} + 5'(ROT_PER_CYCLE)) == 5'(ROT_STEPS));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)                 state_d = SEARCH;
            SEARCH:  if (sel_hit || last_step)         state_d = DONE;
            DONE:    if (out_valid_q && bus.out_ready) state_d = IDLE;
            default:                                   state_d = IDLE;
        endcase
    end

    // Datapath and result registers. The result is latched on entry to DONE
    // and presented one cycle later from a register, so out_valid and the
    // result fields all come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q     <= '0;
            allow_inv_q <= 1'b0;
            rot_cnt_q   <= '0;
            found_q     <= 1'b0;
            inv_q       <= 1'b0;
            operand_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (bus.in_valid) begin
                        value_q     <= bus.in_value;
                        allow_inv_q <= bus.in_allow_inv;
                        rot_cnt_q   <= '0;
                    end
                end
                SEARCH: begin
                    out_valid_q <= 1'b0;
                    if (sel_hit) begin
                        found_q   <= 1'b1;
                        inv_q     <= sel_inv;
                        operand_q <= {sel_rot, sel_imm};
                    end else if (last_step) begin
                        found_q   <= 1'b0;
                        inv_q     <= 1'b0;
                        operand_q <= '0;
                    end else begin
                        rot_cnt_q <= rot_cnt_q + 4'(ROT_PER_CYCLE);
                    end
                end
                DONE: begin
                    out_valid_q <= !(out_valid_q && bus.out_ready);
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs.
    always_comb begin
        bus.in_ready    = (state_q == IDLE);
        bus.out_valid   = out_valid_q;
        bus.out_found   = found_q;
        bus.out_inv     = inv_q;
        bus.out_operand = operand_q;
    end

endmodule

// File: tb/tb_imm12_encoder.sv
// Directed test of imm12_encoder: one ROT_PER_CYCLE=1 and one ROT_PER_CYCLE=16 instance in lockstep.
// Latency: both instances receive every request on the same edge; each latency is measured separately.
// Backpressure: results are held with out_ready=0 for a few cycles before being consumed.
module tb_imm12_encoder;
    import imm12_encoder_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    imm12_encoder_if b1 ();
    imm12_encoder_if b16 ();

    imm12_encoder #(.ROT_PER_CYCLE(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    imm12_encoder #(.ROT_PER_CYCLE(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_in(input logic v, input logic [31:0] val, input logic ai);
        b1.in_valid      = v;
        b1.in_value      = val;
        b1.in_allow_inv  = ai;
        b16.in_valid     = v;
        b16.in_value     = val;
        b16.in_allow_inv = ai;
    endtask

    task automatic set_out_ready(input logic r);
        b1.out_ready  = r;
        b16.out_ready = r;
    endtask

    // Issue one request, measure latency on both instances, check the result,
    // hold it for 'hold' cycles, then consume it.
    task automatic do_req(input string name, input logic [31:0] v, input logic ai,
                          input logic ef, input logic ei, input logic [11:0] eop,
                          input int elat1, input int hold);
        int la;
        int lb;
        @(negedge clk);
        chk({name, " in_ready1"},  32'(b1.in_ready),  32'd1);
        chk({name, " in_ready16"}, 32'(b16.in_ready), 32'd1);
        drive_in(1'b1, v, ai);
        @(posedge clk);
        #1;
        // Changing in_value after the accept must not affect the result.
        drive_in(1'b0, ~v, ~ai);
        la = 0;
        lb = 0;
        for (int n = 1; n <= 40 && (la == 0 || lb == 0); n++) begin
            @(posedge clk);
            #1;
            if (b1.out_valid && la == 0)  la = n;
            if (b16.out_valid && lb == 0) lb = n;
        end
        chk({name, " latency1"},  32'(la), 32'(elat1));
        chk({name, " latency16"}, 32'(lb), 32'd2);
        chk({name, " found1"},    32'(b1.out_found),    32'(ef));
        chk({name, " inv1"},      32'(b1.out_inv),      32'(ei));
        chk({name, " operand1"},  32'(b1.out_operand),  32'(eop));
        chk({name, " found16"},   32'(b16.out_found),   32'(ef));
        chk({name, " inv16"},     32'(b16.out_inv),     32'(ei));
        chk({name, " operand16"}, 32'(b16.out_operand), 32'(eop));
        chk({name, " busy1"},     32'(b1.in_ready),     32'd0);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk({name, " hold valid"},   32'(b1.out_valid),   32'd1);
            chk({name, " hold operand"}, 32'(b1.out_operand), 32'(eop));
            chk({name, " hold found"},   32'(b1.out_found),   32'(ef));
            chk({name, " hold ready"},   32'(b1.in_ready),    32'd0);
        end
        set_out_ready(1'b1);
        @(posedge clk);
        #1;
        set_out_ready(1'b0);
        chk({name, " drop valid1"},  32'(b1.out_valid),  32'd0);
        chk({name, " drop valid16"}, 32'(b16.out_valid), 32'd0);
        chk({name, " idle ready1"},  32'(b1.in_ready),   32'd1);
        chk({name, " idle ready16"}, 32'(b16.in_ready),  32'd1);
    endtask

    initial begin
        logic seen;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive_in(1'b0, 32'h0, 1'b0);
        set_out_ready(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready",    32'(b1.in_ready),     32'd1);
        chk("reset out_valid",   32'(b1.out_valid),    32'd0);
        chk("reset found",       32'(b1.out_found),    32'd0);
        chk("reset inv",         32'(b1.out_inv),      32'd0);
        chk("reset operand",     32'(b1.out_operand),  32'd0);
        chk("reset out_valid16", 32'(b16.out_valid),   32'd0);
        chk("reset operand16",   32'(b16.out_operand), 32'd0);
        rst_n = 1'b1;

        //      name        value          inv   found inv  operand  lat1 hold
        do_req("ff",        32'h000000FF, 1'b0, 1'b1, 1'b0, 12'h0FF, 2,  0);
        do_req("ff000000",  32'hFF000000, 1'b0, 1'b1, 1'b0, 12'h4FF, 6,  0);
        do_req("104",       32'h00000104, 1'b0, 1'b1, 1'b0, 12'hF41, 17, 0);
        do_req("3fc",       32'h000003FC, 1'b0, 1'b1, 1'b0, 12'hFFF, 17, 0);
        do_req("101 inv",   32'h00000101, 1'b1, 1'b0, 1'b0, 12'h000, 17, 0);
        do_req("ffffff00i", 32'hFFFFFF00, 1'b1, 1'b1, 1'b1, 12'h0FF, 2,  0);
        do_req("ffffff00",  32'hFFFFFF00, 1'b0, 1'b0, 1'b0, 12'h000, 17, 0);
        do_req("zero",      32'h00000000, 1'b1, 1'b1, 1'b0, 12'h000, 2,  0);
        do_req("ones inv",  32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 12'h000, 2,  0);
        do_req("ones",      32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 12'h000, 17, 0);
        do_req("backpress", 32'hFF000000, 1'b0, 1'b1, 1'b0, 12'h4FF, 6,  5);
        do_req("after bp",  32'h000000FF, 1'b0, 1'b1, 1'b0, 12'h0FF, 2,  0);

        // Reset during SEARCH (x1 instance) and in DONE (x16 instance).
        @(negedge clk);
        drive_in(1'b1, 32'h00000104, 1'b0);
        @(posedge clk);
        #1;
        drive_in(1'b0, 32'h0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort out_valid1",  32'(b1.out_valid),   32'd0);
        chk("abort out_valid16", 32'(b16.out_valid),  32'd0);
        chk("abort in_ready1",   32'(b1.in_ready),    32'd1);
        chk("abort found16",     32'(b16.out_found),  32'd0);
        chk("abort operand16",   32'(b16.out_operand), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (b1.out_valid || b16.out_valid) seen = 1'b1;
        end
        chk("abort no result",   32'(seen),          32'd0);
        chk("abort ready after", 32'(b1.in_ready),   32'd1);
        chk("abort ready16",     32'(b16.in_ready),  32'd1);

        do_req("post reset", 32'h00000104, 1'b0, 1'b1, 1'b0, 12'hF41, 17, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
